led_frame_loader: RTL

Upstream feeder for the WS2812-style LED serializer. Accepts a byte-wide valid/ready word stream, such as one from the UART/SPI front end, and assembles one full frame of colour words in a shadow buffer. When the last word of the frame arrives, it copies the shadow buffer into the parallel `data` bus in a single cycle. The serializer's parallel bus never carries a partial frame; stalled or restarted frames are discarded and flagged.

---
 rtl/led_frame_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/led_frame_loader.sv
// Assembles a byte stream into a shadow frame buffer and commits it to the
// serializer's parallel data bus in one cycle once the frame is complete.
module led_frame_loader #(
    parameter int unsigned LED_CNT        = 3,
    parameter int unsigned CHANNELS       = 3,
    parameter int unsigned BITPERCHANNEL  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [BITPERCHANNEL-1:0]                    in_data,
    input  logic                                        in_valid,
    input  logic                                        in_sof,
    output logic                                        in_ready,
    output logic [LED_CNT*CHANNELS*BITPERCHANNEL-1:0]   data,
    output logic                                        frame_done,
    output logic                                        err
);
    localparam int unsigned W         = BITPERCHANNEL;
    localparam int unsigned WORDS     = LED_CNT * CHANNELS;
    localparam int unsigned DATAWIDTH = WORDS * W;
    localparam int unsigned CNT_W     = $clog2(WORDS + 1);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [W-1:0]         shadow [WORDS];
    logic [DATAWIDTH-1:0] shadow_flat;
    logic [CNT_W-1:0]     cnt, cnt_nxt, wr_slot;
    logic [TO_W-1:0]      tcnt, tcnt_nxt;
    logic                 xfer, timeout_hit, wr_en, commit, err_nxt, done_nxt;

    assign xfer        = in_valid && in_ready;
    assign timeout_hit = (tcnt >= TO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer && in_sof) state_nxt = (WORDS == 1) ? COMMIT : RECV;
            end
            RECV: begin
                if (xfer) begin
                    if (!in_sof && cnt == CNT_W'(WORDS - 1)) state_nxt = COMMIT;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath control; a transfer always beats the timeout
    always_comb begin
        in_ready = (state != COMMIT) && !reset;
        wr_en    = 1'b0;
        wr_slot  = '0;
        cnt_nxt  = cnt;
        tcnt_nxt = tcnt;
        err_nxt  = 1'b0;
        done_nxt = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                if (xfer && in_sof) begin
                    wr_en   = 1'b1;
                    cnt_nxt = CNT_W'(1);
                end
            end
            RECV: begin
                if (xfer) begin
                    tcnt_nxt = '0;
                    wr_en    = 1'b1;
                    if (in_sof) begin
                        err_nxt = 1'b1;
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        wr_slot = cnt;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (timeout_hit) begin
                    err_nxt  = 1'b1;
                    cnt_nxt  = '0;
                    tcnt_nxt = '0;
                end else if (tcnt != TO_W'(TIMEOUT_CYCLES)) begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                done_nxt = 1'b1;
                cnt_nxt  = '0;
                tcnt_nxt = '0;
            end
            default: begin
                cnt_nxt  = '0;
                tcnt_nxt = '0;
            end
        endcase
    end

    // Word k lands in the k-th most significant W-bit lane
    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            shadow_flat[DATAWIDTH-1-k*W -: W] = shadow[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(WORDS); k++) begin
            if (wr_en && wr_slot == CNT_W'(k)) shadow[k] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            tcnt       <= '0;
            data       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
            frame_done <= done_nxt;
            err        <= err_nxt;
            if (commit) data <= shadow_flat;
        end
    end
endmodule
